decrypter: RTL and testbench

DECRYPTER -- requirements
Module: decrypter

---
 rtl/cipher_pkg.sv | 44 ++++
 rtl/feistel_dec_round.sv | 23 ++
 rtl/decrypter.sv | 89 ++++++++
 tb/tb_decrypter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared definitions for the Feistel encrypter/decrypter pair.
// Contents: block/half widths, default round count and rotate amount,
// FSM state encoding, and the round-key and round-function helpers.
package cipher_pkg;

  localparam int BLOCK_W = 64;
  localparam int HALF_W  = 32;
  localparam int ROUNDS  = 8;
  localparam int ROT     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Left rotate of a 32-bit word; amounts wrap modulo the word width.
  function automatic logic [HALF_W-1:0] rotl32(input logic [HALF_W-1:0] x,
                                               input int amt);
    int s;
    s = amt % HALF_W;
    if (s == 0) return x;
    return (x << s) | (x >> (HALF_W - s));
  endfunction

  // Round key i: upper half of the 64-bit key rotated left by 8*i bits.
  // Computed on the fly so no key schedule has to be stored.
  function automatic logic [HALF_W-1:0] round_key(input logic [BLOCK_W-1:0] key,
                                                  input int idx);
    int                 s;
    logic [BLOCK_W-1:0] kr;
    s  = (8 * idx) % BLOCK_W;
    kr = (s == 0) ? key : ((key << s) | (key >> (BLOCK_W - s)));
    return kr[BLOCK_W-1 -: HALF_W];
  endfunction

  // Round function F(X,K) = rotl32(X ^ K, rot) + K, modulo 2^32.
  function automatic logic [HALF_W-1:0] f_func(input logic [HALF_W-1:0] x,
                                               input logic [HALF_W-1:0] k,
                                               input int rot);
    return rotl32(x ^ k, rot) + k;
  endfunction

endpackage

// File: rtl/feistel_dec_round.sv
// One combinational decryption round; the inverse of the encrypter round
// L' = R, R' = L ^ F(R,K).
// Ports:
//   l, r         current halves
//   k_i          round key for this step
//   l_new, r_new halves after undoing one encryption round
module feistel_dec_round #(
  parameter int ROT = cipher_pkg::ROT
) (
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [31:0] k_i,
  output logic [31:0] l_new,
  output logic [31:0] r_new
);

  import cipher_pkg::*;

  // The encrypter's new L is its old R, so F is applied to our L.
  assign r_new = l;
  assign l_new = r ^ f_func(l, k_i, ROT);

endmodule

// File: rtl/decrypter.sv
// Iterative Feistel decrypter: one round per clock using a single shared
// round block, keys applied in descending order.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   set       start pulse; restarts from any state
//   data_in   ciphertext, bit 0 is MSB
//   key_in    64-bit key
//   data_out  recovered plaintext, held until the next accepted set
//   status    high while data_out holds a fresh result
module decrypter #(
  parameter int ROUNDS = cipher_pkg::ROUNDS,
  parameter int ROT    = cipher_pkg::ROT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic [0:63] data_in,
  input  logic [0:63] key_in,
  output logic [0:63] data_out,
  output logic        status
);

  import cipher_pkg::*;

  localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [HALF_W-1:0]  l_q;
  logic [HALF_W-1:0]  r_q;
  logic [BLOCK_W-1:0] key_q;
  logic [HALF_W-1:0]  k_i;
  logic [HALF_W-1:0]  l_new;
  logic [HALF_W-1:0]  r_new;

  // Round index is the counter itself, so the key for round i comes
  // straight from the latched key.
  assign k_i = round_key(key_q, int'(cnt));

  feistel_dec_round #(.ROT(ROT)) u_round (
    .l     (l_q),
    .r     (r_q),
    .k_i   (k_i),
    .l_new (l_new),
    .r_new (r_new)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain rounds within a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      l_q      <= '0;
      r_q      <= '0;
      key_q    <= '0;
      data_out <= '0;
      status   <= 1'b0;
    end else if (set) begin
      // Accepted in every state: a set during RUN/DONE restarts cleanly.
      // data_out is left alone so it keeps the previous result.
      l_q    <= data_in[0:31];
      r_q    <= data_in[32:63];
      key_q  <= key_in;
      cnt    <= CNT_W'(ROUNDS - 1);
      status <= 1'b0;
      state  <= RUN;
    end else begin
      case (state)
        IDLE: ;
        RUN: begin
          l_q <= l_new;
          r_q <= r_new;
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        // Publishing one cycle after the last round gives the ROUNDS+1
        // latency and keeps intermediate values off data_out.
        DONE: begin
          data_out <= {l_q, r_q};
          status   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decrypter.sv
// Self-checking bench for decrypter. A reference encrypter produces
// ciphertexts; the matching plaintext is queued as the expected result and
// compared when status rises.
module tb_decrypter;

  logic        clk = 1'b0;
  logic        rst;
  logic        set;
  logic [0:63] data_in;
  logic [0:63] key_in;
  logic [0:63] data_out;
  logic        status;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] prev_out;

  decrypter dut (
    .clk      (clk),
    .rst      (rst),
    .set      (set),
    .data_in  (data_in),
    .key_in   (key_in),
    .data_out (data_out),
    .status   (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encrypter, 8 rounds, rotate 5.
  function automatic logic [63:0] enc(input logic [63:0] p, input logic [63:0] k);
    logic [31:0] l, r, ki, x, t;
    logic [63:0] kr;
    l  = p[63:32];
    r  = p[31:0];
    kr = k;
    for (int i = 0; i < 8; i++) begin
      ki     = kr[63:32];
      x      = r ^ ki;
      t      = {x[26:0], x[31:27]} + ki;
      {l, r} = {r, l ^ t};
      kr     = {kr[55:0], kr[63:56]};
    end
    return {l, r};
  endfunction

  // Drive one start pulse; optionally release reset on the same negedge so
  // the very first edge after release samples set.
  task automatic start(input logic [63:0] c, input logic [63:0] k,
                       input logic [63:0] p, input bit release_rst);
    @(negedge clk);
    if (release_rst) rst = 1'b0;
    data_in = c;
    key_in  = k;
    set     = 1'b1;
    @(posedge clk);
    #1 set = 1'b0;
    exp_q.push_back(p);
  endtask

  // Wait (bounded) for status; check latency, output stability while busy,
  // and the result against the scoreboard.
  task automatic wait_done(input string tag, input bit scramble);
    int          lat;
    bit          stable;
    logic [63:0] e;
    lat    = 0;
    stable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (status) begin
        lat = n;
        break;
      end
      if (data_out !== prev_out) stable = 1'b0;
      if (scramble) begin
        data_in = {$urandom, $urandom};
        key_in  = {$urandom, $urandom};
      end
    end
    check({tag, "_stable"}, 64'(stable), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'd9);
    check({tag, "_queue"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, data_out, e);
      prev_out = e;
    end
  endtask

  initial begin
    logic [63:0] p, k;
    bit          rose;

    rst      = 1'b1;
    set      = 1'b0;
    data_in  = '0;
    key_in   = '0;
    prev_out = '0;

    #2;
    check("reset_status", 64'(status), 64'd0);
    check("reset_data", data_out, 64'd0);
    repeat (2) @(posedge clk);

    // Known vector, started on the first edge after reset release.
    start(64'h40100001_00000008, 64'd0, 64'h00000001_00000000, 1'b1);
    wait_done("vec1", 1'b0);

    // All-zero block; status and result must hold afterwards.
    start(64'd0, 64'd0, 64'd0, 1'b0);
    wait_done("zero", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("zero_hold_status", 64'(status), 64'd1);
    check("zero_hold_data", data_out, 64'd0);

    // Loopback against the reference encrypter.
    p = 64'h0123456789abcdef;
    k = 64'h0102030405060708;
    start(enc(p, k), k, 64'h0123456789abcdef, 1'b0);
    wait_done("loop", 1'b0);

    // Random loopbacks with inputs scrambled while running.
    for (int i = 0; i < 4; i++) begin
      p = {$urandom, $urandom};
      k = {$urandom, $urandom};
      start(enc(p, k), k, p, 1'b0);
      wait_done("rand", 1'b1);
    end

    // Restart in the middle of RUN: first job is abandoned.
    p = 64'hdeadbeef_cafef00d;
    k = 64'h00112233_44556677;
    start(enc(p, k), k, p, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("restart_busy", 64'(status), 64'd0);
    void'(exp_q.pop_back());
    p = 64'h13579bdf_2468ace0;
    k = 64'hfedcba98_76543210;
    start(enc(p, k), k, p, 1'b0);
    wait_done("restart", 1'b0);

    // Reset in the middle of RUN: outputs clear at once, nothing follows.
    p = 64'h0f0f0f0f_f0f0f0f0;
    k = 64'h55aa55aa_aa55aa55;
    start(enc(p, k), k, p, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_status", 64'(status), 64'd0);
    check("midrst_data", data_out, 64'd0);
    void'(exp_q.pop_back());
    prev_out = '0;
    @(negedge clk);
    rst  = 1'b0;
    rose = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (status) rose = 1'b1;
    end
    check("midrst_no_status", 64'(rose), 64'd0);
    check("midrst_data_after", data_out, 64'd0);

    // Normal operation resumes after the aborted run.
    start(enc(p, k), k, p, 1'b0);
    wait_done("post_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
